// File: rtl/apb_fifo_dma_if.sv
// Bus bundle for apb_fifo_dma: APB slave port, DMAC peripheral handshake and interrupt.
// The slave modport is the block's view; master is the view of the bridge/DMAC side.
interface apb_fifo_dma_if #(
    parameter int ADDR_BITS = 12
);
    logic                 apb_psel;
    logic                 apb_penable;
    logic                 apb_pwrite;
    logic [ADDR_BITS-1:0] apb_paddr;
    logic [31:0]          apb_pwdata;
    logic [3:0]           apb_pstrb;
    logic [2:0]           apb_pprot;
    logic                 apb_pready;
    logic                 apb_pslverr;
    logic [31:0]          apb_prdata;
    logic                 dma_breq;
    logic                 dma_sreq;
    logic                 dma_lbreq;
    logic                 dma_lsreq;
    logic                 dma_clr;
    logic                 dma_tc;
    logic                 irq;

    modport slave (
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata, apb_pstrb, apb_pprot,
        input  dma_clr, dma_tc,
        output apb_pready, apb_pslverr, apb_prdata,
        output dma_breq, dma_sreq, dma_lbreq, dma_lsreq, irq
    );

    modport master (
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata, apb_pstrb, apb_pprot,
        output dma_clr, dma_tc,
        input  apb_pready, apb_pslverr, apb_prdata,
        input  dma_breq, dma_sreq, dma_lbreq, dma_lsreq, irq
    );
endinterface

// File: rtl/apb_fifo_dma.sv
// APB-accessible word FIFO drained by a DMAC through the single/burst request handshake.
// Zero-wait-state slave; DMA requests are held until the DMAC acknowledges with dma_clr.
module apb_fifo_dma #(
    parameter int ADDR_BITS = 12,
    parameter int DEPTH     = 16,
    parameter int BURST     = 4
) (
    input logic           bus_clock,
    input logic           resetn,
    apb_fifo_dma_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] BURST_LVL = PW'(BURST);
    localparam logic [15:0]   BURST_CNT = 16'(BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } dma_state_e;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          dma_en_q, dma_en_d;
    logic          flush_q, flush_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    irq_en_q, irq_en_d;
    logic          burst_q, burst_d;
    logic          last_q, last_d;
    dma_state_e    state_q, state_d;
    logic [31:0]   mem_q [DEPTH];

    logic [PW-1:0] level;
    logic          full;
    logic          empty;
    logic          thr;
    logic          xfer;
    logic          wr_x;
    logic          rd_x;
    logic [1:0]    reg_sel;
    logic          push_req;
    logic          pop_req;
    logic          strb_ok;
    logic          push_ok;
    logic          pop_ok;
    logic [31:0]   stat_word;
    logic [31:0]   ctrl_word;
    logic [ADDR_BITS-1:0] paddr_unused;
    logic [2:0]    pprot_unused;

    assign paddr_unused = bus.apb_paddr;
    assign pprot_unused = bus.apb_pprot;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign thr   = (level >= BURST_LVL);

    assign xfer     = bus.apb_psel & bus.apb_penable;
    assign wr_x     = xfer & bus.apb_pwrite;
    assign rd_x     = xfer & ~bus.apb_pwrite;
    assign reg_sel  = bus.apb_paddr[3:2];
    assign push_req = wr_x && (reg_sel == 2'd0);
    assign pop_req  = rd_x && (reg_sel == 2'd0);
    assign strb_ok  = (bus.apb_pstrb == 4'hF);
    assign push_ok  = push_req & strb_ok & ~full;
    assign pop_ok   = pop_req & ~empty;

    assign stat_word = {16'(level), 9'd0, done_q, ovf_q, thr, 2'd0, full, empty};
    assign ctrl_word = {25'd0, irq_en_q, 2'd0, flush_q, dma_en_q};

    assign bus.apb_pready  = 1'b1;
    assign bus.apb_pslverr = (push_req & (~strb_ok | full)) | (pop_req & empty);
    assign bus.irq         = |({done_q, ovf_q, thr} & irq_en_q);

    assign bus.dma_breq  = (state_q == S_REQ) &  burst_q & ~last_q;
    assign bus.dma_lbreq = (state_q == S_REQ) &  burst_q &  last_q;
    assign bus.dma_sreq  = (state_q == S_REQ) & ~burst_q & ~last_q;
    assign bus.dma_lsreq = (state_q == S_REQ) & ~burst_q &  last_q;

    always_comb begin
        bus.apb_prdata = 32'd0;
        if (rd_x) begin
            case (reg_sel)
                2'd0:    bus.apb_prdata = pop_ok ? mem_q[rd_ptr_q[AW-1:0]] : 32'd0;
                2'd1:    bus.apb_prdata = stat_word;
                2'd2:    bus.apb_prdata = ctrl_word;
                default: bus.apb_prdata = {16'd0, cnt_q};
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dma_en_d = dma_en_q;
        flush_d  = 1'b0;
        done_d   = done_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        burst_d  = burst_q;
        last_d   = last_q;
        state_d  = state_q;

        if (flush_q) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // W1C first so a same-cycle hardware event still sets the flag.
        if (wr_x && reg_sel == 2'd1) begin
            if (bus.apb_pwdata[6]) done_d = 1'b0;
            if (bus.apb_pwdata[5]) ovf_d  = 1'b0;
        end
        if (push_req && full) ovf_d = 1'b1;

        if (wr_x && reg_sel == 2'd2) begin
            dma_en_d = bus.apb_pwdata[0];
            flush_d  = bus.apb_pwdata[1];
            irq_en_d = bus.apb_pwdata[6:4];
        end

        if (wr_x && reg_sel == 2'd3 && bus.apb_pstrb != 4'd0) cnt_d = bus.apb_pwdata[15:0];
        if (pop_ok && state_q == S_REQ && cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;

        case (state_q)
            S_IDLE: begin
                if (dma_en_q && cnt_q != 16'd0 && !empty) begin
                    burst_d = thr && (cnt_q >= BURST_CNT);
                    last_d  = (cnt_q == (burst_d ? BURST_CNT : 16'd1));
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // The request may only be withdrawn by the DMAC's acknowledge.
                if (bus.dma_clr) begin
                    state_d = S_HOLD;
                    if (bus.dma_tc || last_q) begin
                        dma_en_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge bus_clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= 16'd0;
            dma_en_q <= 1'b0;
            flush_q  <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            irq_en_q <= 3'd0;
            burst_q  <= 1'b0;
            last_q   <= 1'b0;
            state_q  <= S_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dma_en_q <= dma_en_d;
            flush_q  <= flush_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            burst_q  <= burst_d;
            last_q   <= last_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge bus_clock) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= bus.apb_pwdata;
    end
endmodule

// File: tb/tb_apb_fifo_dma.sv
// Self-checking bench for apb_fifo_dma: APB register/FIFO behaviour, DMA request sequencing,
// interrupt gating and asynchronous reset, with a scoreboard of pushed FIFO words.
module tb_apb_fifo_dma;
    localparam logic [11:0] A_DATA = 12'h000;
    localparam logic [11:0] A_STAT = 12'h004;
    localparam logic [11:0] A_CTRL = 12'h008;
    localparam logic [11:0] A_CNT  = 12'h00C;

    logic bus_clock;
    logic resetn;
    int   compareCount;
    int   failCount;
    logic [31:0] expectedWords[$];
    logic [31:0] rdata;
    logic        err;

    apb_fifo_dma_if #(.ADDR_BITS(12)) bus ();

    apb_fifo_dma #(.ADDR_BITS(12), .DEPTH(16), .BURST(4)) dut (
        .bus_clock (bus_clock),
        .resetn    (resetn),
        .bus       (bus)
    );

    initial bus_clock = 1'b0;
    always #5 bus_clock = ~bus_clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [3:0] reqVec();
        return {bus.dma_breq, bus.dma_sreq, bus.dma_lbreq, bus.dma_lsreq};
    endfunction

    // One APB transfer; response is sampled mid access phase, state commits on the following edge.
    task automatic applyStimulus(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [31:0] rd, output logic er);
        @(negedge bus_clock);
        bus.apb_psel    = 1'b1;
        bus.apb_penable = 1'b0;
        bus.apb_pwrite  = wr;
        bus.apb_paddr   = addr;
        bus.apb_pwdata  = data;
        bus.apb_pstrb   = strb;
        @(negedge bus_clock);
        bus.apb_penable = 1'b1;
        #1;
        rd = bus.apb_prdata;
        er = bus.apb_pslverr;
        @(posedge bus_clock);
        #1;
        bus.apb_psel    = 1'b0;
        bus.apb_penable = 1'b0;
        bus.apb_pwrite  = 1'b0;
    endtask

    task automatic writeReg(input string tag, input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] r;
        logic e;
        applyStimulus(1'b1, addr, data, 4'hF, r, e);
        checkOutput({tag, "_err"}, 32'(e), 32'd0);
    endtask

    task automatic readReg(input string tag, input logic [11:0] addr, input logic [31:0] expected);
        logic [31:0] r;
        logic e;
        applyStimulus(1'b0, addr, 32'd0, 4'h0, r, e);
        checkOutput(tag, r, expected);
    endtask

    task automatic pushWord(input logic [31:0] w);
        logic [31:0] r;
        logic e;
        applyStimulus(1'b1, A_DATA, w, 4'hF, r, e);
        checkOutput("push_err", 32'(e), 32'd0);
        expectedWords.push_back(w);
    endtask

    task automatic popWord(input string tag);
        logic [31:0] r;
        logic [31:0] exp;
        logic e;
        exp = expectedWords.pop_front();
        applyStimulus(1'b0, A_DATA, 32'd0, 4'h0, r, e);
        checkOutput(tag, r, exp);
        checkOutput({tag, "_err"}, 32'(e), 32'd0);
    endtask

    task automatic waitReq(input string tag, input logic [3:0] expected);
        logic [3:0] v;
        v = 4'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge bus_clock);
            v = reqVec();
            if (v != 4'd0) break;
        end
        checkOutput(tag, 32'(v), 32'(expected));
    endtask

    task automatic dmaClear(input logic tc);
        @(negedge bus_clock);
        bus.dma_clr = 1'b1;
        bus.dma_tc  = tc;
        @(posedge bus_clock);
        #1;
        bus.dma_clr = 1'b0;
        bus.dma_tc  = 1'b0;
    endtask

    task automatic checkHold(input string tag);
        @(negedge bus_clock);
        checkOutput(tag, 32'(reqVec()), 32'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_dma"}, 32'({reqVec(), bus.irq}), 32'd0);
        checkOutput({tag, "_pready"}, 32'(bus.apb_pready), 32'd1);
        checkOutput({tag, "_pslverr"}, 32'(bus.apb_pslverr), 32'd0);
        checkOutput({tag, "_prdata"}, bus.apb_prdata, 32'd0);
    endtask

    initial begin
        compareCount    = 0;
        failCount       = 0;
        resetn          = 1'b0;
        bus.apb_psel    = 1'b0;
        bus.apb_penable = 1'b0;
        bus.apb_pwrite  = 1'b0;
        bus.apb_paddr   = 12'd0;
        bus.apb_pwdata  = 32'd0;
        bus.apb_pstrb   = 4'd0;
        bus.apb_pprot   = 3'd0;
        bus.dma_clr     = 1'b0;
        bus.dma_tc      = 1'b0;
        repeat (3) @(negedge bus_clock);
        checkIdleOutputs("reset");
        resetn = 1'b1;

        // Empty FIFO after reset; popping is an error returning zero.
        readReg("stat_reset", A_STAT, 32'h0000_0001);
        applyStimulus(1'b0, A_DATA, 32'd0, 4'h0, rdata, err);
        checkOutput("pop_empty_err", 32'(err), 32'd1);
        checkOutput("pop_empty_data", rdata, 32'd0);

        // Fill to full, overflow, then drain in order.
        for (int i = 0; i < 16; i++) pushWord(32'hA5A5_0000 + 32'(i));
        readReg("stat_full", A_STAT, 32'h0010_0012);
        applyStimulus(1'b1, A_DATA, 32'hDEAD_BEEF, 4'hF, rdata, err);
        checkOutput("push_full_err", 32'(err), 32'd1);
        readReg("stat_ovf", A_STAT, 32'h0010_0032);
        for (int i = 0; i < 16; i++) popWord("drain");
        readReg("stat_drained", A_STAT, 32'h0000_0021);
        writeReg("w1c_ovf", A_STAT, 32'h0000_0020);
        readReg("stat_ovf_clr", A_STAT, 32'h0000_0001);
        applyStimulus(1'b1, A_DATA, 32'h1234_5678, 4'h3, rdata, err);
        checkOutput("push_strb_err", 32'(err), 32'd1);
        readReg("stat_strb", A_STAT, 32'h0000_0001);

        // Three single requests, the last one flagged as last.
        for (int i = 0; i < 3; i++) pushWord(32'h3000_0000 + 32'(i));
        writeReg("cnt3", A_CNT, 32'd3);
        writeReg("en3", A_CTRL, 32'h1);
        waitReq("s3_req1", 4'b0100);
        popWord("s3_pop1");
        dmaClear(1'b0);
        checkHold("s3_hold1");
        waitReq("s3_req2", 4'b0100);
        popWord("s3_pop2");
        dmaClear(1'b0);
        checkHold("s3_hold2");
        waitReq("s3_req3", 4'b0001);
        popWord("s3_pop3");
        dmaClear(1'b0);
        readReg("s3_stat", A_STAT, 32'h0000_0041);
        readReg("s3_ctrl", A_CTRL, 32'h0);
        readReg("s3_cnt", A_CNT, 32'h0);
        writeReg("s3_w1c", A_STAT, 32'h40);

        // Burst then last burst.
        for (int i = 0; i < 8; i++) pushWord(32'h4000_0000 + 32'(i));
        writeReg("cnt8", A_CNT, 32'd8);
        writeReg("en4", A_CTRL, 32'h1);
        waitReq("s4_breq", 4'b1000);
        for (int i = 0; i < 4; i++) popWord("s4_pop_a");
        dmaClear(1'b0);
        checkHold("s4_hold");
        waitReq("s4_lbreq", 4'b0010);
        readReg("s4_cnt_mid", A_CNT, 32'd4);
        for (int i = 0; i < 4; i++) popWord("s4_pop_b");
        dmaClear(1'b0);
        readReg("s4_cnt", A_CNT, 32'h0);
        readReg("s4_stat", A_STAT, 32'h0000_0041);
        writeReg("s4_w1c", A_STAT, 32'h40);

        // Done interrupt gated by CTRL[6], cleared by W1C.
        for (int i = 0; i < 8; i++) pushWord(32'h5000_0000 + 32'(i));
        writeReg("cnt8b", A_CNT, 32'd8);
        writeReg("en5", A_CTRL, 32'h41);
        waitReq("s5_breq", 4'b1000);
        checkOutput("s5_irq_low", 32'(bus.irq), 32'd0);
        for (int i = 0; i < 4; i++) popWord("s5_pop_a");
        dmaClear(1'b0);
        waitReq("s5_lbreq", 4'b0010);
        for (int i = 0; i < 4; i++) popWord("s5_pop_b");
        dmaClear(1'b0);
        @(negedge bus_clock);
        checkOutput("s5_irq_high", 32'(bus.irq), 32'd1);
        writeReg("s5_w1c", A_STAT, 32'h40);
        @(negedge bus_clock);
        checkOutput("s5_irq_clr", 32'(bus.irq), 32'd0);

        // Terminal count on the first acknowledge ends the transfer early.
        for (int i = 0; i < 8; i++) pushWord(32'h6000_0000 + 32'(i));
        writeReg("cnt8c", A_CNT, 32'd8);
        writeReg("en6", A_CTRL, 32'h1);
        waitReq("tc_breq", 4'b1000);
        for (int i = 0; i < 4; i++) popWord("tc_pop");
        dmaClear(1'b1);
        repeat (4) @(negedge bus_clock);
        checkOutput("tc_no_req", 32'(reqVec()), 32'd0);
        readReg("tc_stat", A_STAT, 32'h0004_0050);
        readReg("tc_ctrl", A_CTRL, 32'h0);
        readReg("tc_cnt", A_CNT, 32'd4);
        for (int i = 0; i < 4; i++) popWord("tc_cpu_pop");
        readReg("tc_cnt_after", A_CNT, 32'd4);
        writeReg("tc_w1c", A_STAT, 32'h40);

        // Flush discards contents and self-clears.
        pushWord(32'h7000_0000);
        pushWord(32'h7000_0001);
        writeReg("flush", A_CTRL, 32'h2);
        expectedWords.delete();
        readReg("flush_stat", A_STAT, 32'h0000_0001);
        readReg("flush_ctrl", A_CTRL, 32'h0);

        // Asynchronous reset in the middle of a burst request.
        for (int i = 0; i < 5; i++) pushWord(32'h8000_0000 + 32'(i));
        writeReg("cnt5", A_CNT, 32'd5);
        writeReg("en7", A_CTRL, 32'h1);
        waitReq("rst_breq", 4'b1000);
        #2;
        resetn = 1'b0;
        #1;
        checkIdleOutputs("async_rst");
        expectedWords.delete();
        @(negedge bus_clock);
        resetn = 1'b1;
        readReg("rst_stat", A_STAT, 32'h0000_0001);
        readReg("rst_cnt", A_CNT, 32'h0);
        readReg("rst_ctrl", A_CTRL, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule
